cache_assoc_ctrl: RTL and testbench

Parametrised set-associative successor to the direct-mapped instruction cache. It sits between a word-addressed read requester and a slower slave memory, and holds tag, valid and LRU state in flops and line data in a synchronous RAM. Relative to the direct-mapped generation it adds:
- 1- or 2-way associativity with LRU replacement;
- critical-word-first line fill with early requester release;
- an explicit flush input.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_data_ram.sv | 35 +++
 rtl/cache_assoc_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_cache_assoc_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package cache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        SINGLE,
        FLUSH
    } state_t;

    // Requester and slave both use 30-bit word addresses
    localparam int ADDR_W = 30;

    // Field widths for the default geometry (8 sets, 32-word lines)
    localparam int OFF_W = 5;
    localparam int SET_W = 3;
    localparam int TAG_W = ADDR_W - SET_W - OFF_W;

    // Field widths for an arbitrary geometry
    function automatic int calc_off_w(input int num_word);
        return num_word;
    endfunction

    function automatic int calc_set_w(input int num_block);
        return num_block;
    endfunction

    function automatic int calc_tag_w(input int num_block, input int num_word);
        return ADDR_W - num_block - num_word;
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Line data storage: one synchronous-read bank per way, shared read address,
// shared write port with a per-way write enable.
module cache_data_ram
    import cache_pkg::*;
#(
    parameter int NUM_WAY = 2,
    parameter int IDX_W   = 8,
    parameter int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic [IDX_W-1:0]               rd_addr,
    output logic [NUM_WAY-1:0][DATA_W-1:0] rd_data,
    input  logic [NUM_WAY-1:0]             wr_en,
    input  logic [IDX_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]              wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    for (genvar w = 0; w < NUM_WAY; w++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;

        // One word written per enabled way; every bank is read each cycle
        always_ff @(posedge clk) begin
            if (wr_en[w]) begin
                mem[wr_addr] <= wr_data;
            end
            rd_q <= mem[rd_addr];
        end

        assign rd_data[w] = rd_q;
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// Set-associative (1 or 2 way) instruction cache controller with LRU
// replacement, critical-word-first fill, uncacheable single-word path and flush.
module cache_assoc_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_BLOCK = 3,
    parameter int NUM_WORD  = 5,
    parameter int NUM_WAY   = 2,
    parameter int DATA_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bypass,
    input  logic              i_cache_dis,
    input  logic              i_flush,
    input  logic [29:0]       i_mem_addr,
    input  logic              i_mem_rd,
    output logic              o_mem_ready,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_slave_sel,
    output logic [29:0]       o_slave_addr,
    input  logic [DATA_W-1:0] i_slave_rdata,
    input  logic              i_slave_ready,
    input  logic [31:0]       i_climit
);

    localparam int OFF_BITS = calc_off_w(NUM_WORD);
    localparam int SET_BITS = calc_set_w(NUM_BLOCK);
    localparam int TAG_BITS = calc_tag_w(NUM_BLOCK, NUM_WORD);
    localparam int IDX_BITS = SET_BITS + OFF_BITS;
    localparam int NUM_SETS = 1 << SET_BITS;

    state_t state;

    logic [ADDR_W-1:0]                  req_addr;
    logic [OFF_BITS-1:0]                fill_cnt;
    logic                               victim_q;
    logic                               flush_pend;

    logic [NUM_SETS-1:0][NUM_WAY-1:0]   valid;
    logic [NUM_SETS-1:0]                lru;
    logic [TAG_BITS-1:0]                tags [NUM_WAY][NUM_SETS];

    logic [SET_BITS-1:0]                req_set;
    logic [TAG_BITS-1:0]                req_tag;
    logic                               uncacheable;
    logic                               slave_beat;
    logic                               fill_beat;
    logic                               fill_last;

    logic                               hit;
    logic                               hit_way;
    logic                               victim;
    logic [DATA_W-1:0]                  hit_data;

    logic [NUM_WAY-1:0][DATA_W-1:0]     rd_data;
    logic [NUM_WAY-1:0]                 wr_en;
    logic [IDX_BITS-1:0]                wr_addr;

    assign req_set = req_addr[IDX_BITS-1:OFF_BITS];
    assign req_tag = req_addr[ADDR_W-1:IDX_BITS];

    // Bypass, disable and everything at or above the cacheable limit go straight to the slave
    assign uncacheable = i_bypass | i_cache_dis | ({i_mem_addr, 2'b00} >= i_climit);

    // A slave ready only counts while a slave request is actually outstanding
    assign slave_beat = o_slave_sel & i_slave_ready;
    assign fill_beat  = (state == FILL) & slave_beat;
    assign fill_last  = fill_beat & (fill_cnt == '1);

    // Fill words land at the line offset currently presented to the slave
    assign wr_addr = {req_set, o_slave_addr[OFF_BITS-1:0]};

    cache_data_ram #(
        .NUM_WAY (NUM_WAY),
        .IDX_W   (IDX_BITS),
        .DATA_W  (DATA_W)
    ) u_data_ram (
        .clk     (i_clk),
        .rd_addr (i_mem_addr[IDX_BITS-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (i_slave_rdata)
    );

    // Only the way chosen as victim at the start of the fill is written
    always_comb begin
        wr_en = '0;
        if (fill_beat) begin
            wr_en[victim_q] = 1'b1;
        end
    end

    // Tag compare over all ways, and victim choice: lowest invalid way, else LRU
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < NUM_WAY; w++) begin
            if (valid[req_set][w] && (tags[w][req_set] == req_tag)) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end

        victim = (NUM_WAY == 2) ? lru[req_set] : 1'b0;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            if (!valid[req_set][w]) begin
                victim = 1'(w);
            end
        end

        hit_data = rd_data[hit_way];
    end

    // Tag is written once the whole line has arrived; valid guards it until then
    always_ff @(posedge i_clk) begin
        if (fill_last) begin
            tags[victim_q][req_set] <= req_tag;
        end
    end

    // Main controller: state, registered outputs, valid/LRU arrays and flush bookkeeping
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            o_mem_ready  <= 1'b0;
            o_mem_rdata  <= '0;
            o_slave_sel  <= 1'b0;
            o_slave_addr <= '0;
            req_addr     <= '0;
            fill_cnt     <= '0;
            victim_q     <= 1'b0;
            flush_pend   <= 1'b0;
            valid        <= '0;
            lru          <= '0;
        end else begin
            o_mem_ready <= 1'b0;

            if (((state == LOOKUP) || (state == FILL) || (state == SINGLE)) &&
                (i_flush || i_cache_dis)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (flush_pend || i_flush) begin
                        state <= FLUSH;
                    end else begin
                        if (i_cache_dis) begin
                            valid <= '0;
                            lru   <= '0;
                        end
                        if (i_mem_rd && !o_mem_ready) begin
                            req_addr <= i_mem_addr;
                            if (uncacheable) begin
                                o_slave_sel  <= 1'b1;
                                o_slave_addr <= i_mem_addr;
                                state        <= SINGLE;
                            end else begin
                                state <= LOOKUP;
                            end
                        end
                    end
                end

                LOOKUP: begin
                    if (hit) begin
                        o_mem_ready <= 1'b1;
                        o_mem_rdata <= hit_data;
                        if (NUM_WAY == 2) begin
                            lru[req_set] <= ~hit_way;
                        end
                        state <= IDLE;
                    end else begin
                        victim_q                <= victim;
                        valid[req_set][victim]  <= 1'b0;
                        fill_cnt                <= '0;
                        o_slave_sel             <= 1'b1;
                        o_slave_addr            <= req_addr;
                        state                   <= FILL;
                    end
                end

                FILL: begin
                    if (slave_beat) begin
                        fill_cnt     <= fill_cnt + OFF_BITS'(1);
                        o_slave_addr <= {o_slave_addr[ADDR_W-1:OFF_BITS],
                                         o_slave_addr[OFF_BITS-1:0] + OFF_BITS'(1)};
                        if (fill_cnt == '0) begin
                            o_mem_ready <= 1'b1;
                            o_mem_rdata <= i_slave_rdata;
                        end
                        if (fill_cnt == '1) begin
                            o_slave_sel               <= 1'b0;
                            valid[req_set][victim_q]  <= 1'b1;
                            if (NUM_WAY == 2) begin
                                lru[req_set] <= ~victim_q;
                            end
                            state <= IDLE;
                        end
                    end
                end

                SINGLE: begin
                    if (slave_beat) begin
                        o_mem_ready <= 1'b1;
                        o_mem_rdata <= i_slave_rdata;
                        o_slave_sel <= 1'b0;
                        state       <= IDLE;
                    end
                end

                FLUSH: begin
                    valid      <= '0;
                    lru        <= '0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl: 8 sets, 4-word lines, 2 ways; the slave
// returns address XOR 0xA5A50000 and answers every other cycle.
module tb_cache_assoc_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_bypass = 1'b0;
    logic        i_cache_dis = 1'b0;
    logic        i_flush = 1'b0;
    logic [29:0] i_mem_addr = '0;
    logic        i_mem_rd = 1'b0;
    logic        o_mem_ready;
    logic [31:0] o_mem_rdata;
    logic        o_slave_sel;
    logic [29:0] o_slave_addr;
    logic [31:0] i_slave_rdata;
    logic        i_slave_ready = 1'b0;
    logic [31:0] i_climit = 32'hFFFF_FFFF;

    int passed = 0;
    int total  = 0;

    int          slave_cnt = 0;
    logic [29:0] slave_log [256];

    cache_assoc_ctrl #(
        .NUM_BLOCK (3),
        .NUM_WORD  (2),
        .NUM_WAY   (2),
        .DATA_W    (32)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_bypass      (i_bypass),
        .i_cache_dis   (i_cache_dis),
        .i_flush       (i_flush),
        .i_mem_addr    (i_mem_addr),
        .i_mem_rd      (i_mem_rd),
        .o_mem_ready   (o_mem_ready),
        .o_mem_rdata   (o_mem_rdata),
        .o_slave_sel   (o_slave_sel),
        .o_slave_addr  (o_slave_addr),
        .i_slave_rdata (i_slave_rdata),
        .i_slave_ready (i_slave_ready),
        .i_climit      (i_climit)
    );

    always #5 i_clk = ~i_clk;

    assign i_slave_rdata = {2'b00, o_slave_addr} ^ 32'hA5A5_0000;

    // Slave model: answers every other cycle while selected and logs each address it serves
    always @(negedge i_clk) begin
        if (o_slave_sel && !i_slave_ready) begin
            i_slave_ready = 1'b1;
            if (slave_cnt < 256) slave_log[slave_cnt] = o_slave_addr;
            slave_cnt = slave_cnt + 1;
        end else begin
            i_slave_ready = 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_mem_rd = 1'b0;
        i_flush = 1'b0;
        i_bypass = 1'b0;
        i_cache_dis = 1'b0;
        i_climit = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // One requester read; reports data, cycles from request to ready, slave activity
    task automatic do_read(input logic [29:0] addr, output logic [31:0] data,
                           output int cycles, output bit sel_seen,
                           output int nslave, output int base);
        bit got;
        got = 1'b0;
        data = '0;
        cycles = 0;
        sel_seen = 1'b0;
        base = slave_cnt;
        @(negedge i_clk);
        i_mem_addr = addr;
        i_mem_rd = 1'b1;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge i_clk);
            if (o_slave_sel) sel_seen = 1'b1;
            if (o_mem_ready) begin
                got = 1'b1;
                cycles = c;
                data = o_mem_rdata;
            end
        end
        i_mem_rd = 1'b0;
        for (int c = 0; c < 100 && o_slave_sel; c++) @(negedge i_clk);
        @(negedge i_clk);
        nslave = slave_cnt - base;
        total++;
        if (!got) $display("FAIL read_timeout addr %h: no o_mem_ready, required one", addr);
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        total++; if (o_mem_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", o_mem_ready); else passed++;
        total++; if (o_mem_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", o_mem_rdata); else passed++;
        total++; if (o_slave_sel !== 1'b0) $display("FAIL rst_sel got %b want 0", o_slave_sel); else passed++;
        total++; if (o_slave_addr !== 30'h0) $display("FAIL rst_saddr got %h want 0", o_slave_addr); else passed++;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_cold_fill();
        logic [31:0] d;
        int cyc, n, b;
        bit sel;
        logic [29:0] exp_addr [4];
        exp_addr = '{30'h102, 30'h103, 30'h100, 30'h101};
        apply_reset();
        do_read(30'h102, d, cyc, sel, n, b);
        total++; if (d !== 32'hA5A5_0102) $display("FAIL cold_data got %h want a5a50102", d); else passed++;
        total++; if (cyc !== 3) $display("FAIL cold_latency got %0d want 3", cyc); else passed++;
        total++; if (n !== 4) $display("FAIL cold_beats got %0d want 4", n); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slave_log[b+i] !== exp_addr[i])
                $display("FAIL cold_saddr%0d got %h want %h", i, slave_log[b+i], exp_addr[i]);
            else passed++;
        end
        do_read(30'h101, d, cyc, sel, n, b);
        total++; if (d !== 32'hA5A5_0101) $display("FAIL hit_data got %h want a5a50101", d); else passed++;
        total++; if (cyc !== 2) $display("FAIL hit_latency got %0d want 2", cyc); else passed++;
        total++; if (sel !== 1'b0) $display("FAIL hit_sel got %b want 0", sel); else passed++;
    endtask

    task automatic test_lru();
        logic [31:0] d;
        int cyc, n, b;
        bit sel;
        apply_reset();
        do_read(30'h000, d, cyc, sel, n, b);
        total++; if (sel !== 1'b1) $display("FAIL lru_fill0 sel got %b want 1", sel); else passed++;
        do_read(30'h020, d, cyc, sel, n, b);
        total++; if (sel !== 1'b1) $display("FAIL lru_fill20 sel got %b want 1", sel); else passed++;
        do_read(30'h000, d, cyc, sel, n, b);
        total++; if (sel !== 1'b0) $display("FAIL lru_rehit0 sel got %b want 0", sel); else passed++;
        do_read(30'h040, d, cyc, sel, n, b);
        total++; if (n !== 4) $display("FAIL lru_fill40 beats got %0d want 4", n); else passed++;
        total++; if (d !== 32'hA5A5_0040) $display("FAIL lru_fill40 data got %h want a5a50040", d); else passed++;
        do_read(30'h000, d, cyc, sel, n, b);
        total++; if (sel !== 1'b0) $display("FAIL lru_keep0 sel got %b want 0", sel); else passed++;
        total++; if (d !== 32'hA5A5_0000) $display("FAIL lru_keep0 data got %h want a5a50000", d); else passed++;
        do_read(30'h020, d, cyc, sel, n, b);
        total++; if (n !== 4) $display("FAIL lru_evict20 beats got %0d want 4", n); else passed++;
        total++; if (d !== 32'hA5A5_0020) $display("FAIL lru_evict20 data got %h want a5a50020", d); else passed++;
    endtask

    task automatic test_uncacheable();
        logic [31:0] d;
        int cyc, n, b;
        bit sel;
        apply_reset();
        i_climit = 32'h0000_0100;
        for (int k = 0; k < 2; k++) begin
            do_read(30'h040, d, cyc, sel, n, b);
            total++; if (n !== 1) $display("FAIL climit_beats%0d got %0d want 1", k, n); else passed++;
            total++; if (d !== 32'hA5A5_0040) $display("FAIL climit_data%0d got %h want a5a50040", k, d); else passed++;
            total++; if (cyc !== 2) $display("FAIL climit_latency%0d got %0d want 2", k, cyc); else passed++;
        end
        i_climit = 32'hFFFF_FFFF;
        do_read(30'h040, d, cyc, sel, n, b);
        total++; if (n !== 4) $display("FAIL climit_noalloc beats got %0d want 4", n); else passed++;
        i_bypass = 1'b1;
        do_read(30'h041, d, cyc, sel, n, b);
        total++; if (n !== 1) $display("FAIL bypass_beats got %0d want 1", n); else passed++;
        total++; if (d !== 32'hA5A5_0041) $display("FAIL bypass_data got %h want a5a50041", d); else passed++;
        i_bypass = 1'b0;
        do_read(30'h042, d, cyc, sel, n, b);
        total++; if (sel !== 1'b0) $display("FAIL bypass_kept sel got %b want 0", sel); else passed++;
        total++; if (d !== 32'hA5A5_0042) $display("FAIL bypass_kept data got %h want a5a50042", d); else passed++;
    endtask

    task automatic test_flush_during_fill();
        logic [31:0] d;
        int cyc, n, b;
        bit sel;
        apply_reset();
        fork
            do_read(30'h102, d, cyc, sel, n, b);
            begin
                int w;
                w = 0;
                while (!o_slave_sel && w < 50) begin
                    @(negedge i_clk);
                    w++;
                end
                @(negedge i_clk);
                i_flush = 1'b1;
                @(negedge i_clk);
                i_flush = 1'b0;
            end
        join
        total++; if (d !== 32'hA5A5_0102) $display("FAIL flush_fill data got %h want a5a50102", d); else passed++;
        total++; if (n !== 4) $display("FAIL flush_fill beats got %0d want 4", n); else passed++;
        do_read(30'h102, d, cyc, sel, n, b);
        total++; if (sel !== 1'b1) $display("FAIL flush_after sel got %b want 1", sel); else passed++;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        int cyc, n, b;
        bit sel;
        apply_reset();
        b = slave_cnt;
        @(negedge i_clk);
        i_mem_addr = 30'h102;
        i_mem_rd = 1'b1;
        for (int c = 0; c < 60 && (slave_cnt - b) < 2; c++) @(negedge i_clk);
        total++; if ((slave_cnt - b) < 2) $display("FAIL midfill_beats got %0d want 2", slave_cnt - b); else passed++;
        @(posedge i_clk);
        #1;
        total++; if (o_slave_sel !== 1'b1) $display("FAIL midfill_sel_before got %b want 1", o_slave_sel); else passed++;
        total++; if (o_mem_rdata !== 32'hA5A5_0102) $display("FAIL midfill_rdata_before got %h want a5a50102", o_mem_rdata); else passed++;
        i_reset = 1'b1;
        i_mem_rd = 1'b0;
        #1;
        total++; if (o_slave_sel !== 1'b0) $display("FAIL midfill_sel got %b want 0", o_slave_sel); else passed++;
        total++; if (o_mem_ready !== 1'b0) $display("FAIL midfill_ready got %b want 0", o_mem_ready); else passed++;
        total++; if (o_mem_rdata !== 32'h0) $display("FAIL midfill_rdata got %h want 0", o_mem_rdata); else passed++;
        total++; if (o_slave_addr !== 30'h0) $display("FAIL midfill_saddr got %h want 0", o_slave_addr); else passed++;
        @(negedge i_clk);
        i_reset = 1'b0;
        do_read(30'h102, d, cyc, sel, n, b);
        total++; if (sel !== 1'b1) $display("FAIL midfill_after sel got %b want 1", sel); else passed++;
        total++; if (d !== 32'hA5A5_0102) $display("FAIL midfill_after data got %h want a5a50102", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_lru();
        test_uncacheable();
        test_flush_during_fill();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
